// File: rtl/exwb_lane_pipe.sv
// exwb_lane_pipe: N-lane EX -> S1(MEM) -> ... -> S[DEPTH](WB) writeback pipeline with forwarding
//   Optional debug trace ports are compiled in when PIPE_DEBUG_EN is defined.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     stall                freeze every stage and suppress commit
//     ex_valid/we/waddr/   per-lane EX bundle; ex_late marks results that arrive at S1
//     ex_wdata/ex_late
//     ex_br_hit/br_lane    mispredict in EX: lanes younger than br_lane are squashed
//     s1_late_data         late results for the S1 entries
//     rd_addr/rd_data_in   EX read ports and register file data
//     rd_data_out          forwarded operands; fwd_hazard flags a late S1 result still pending
//     wb_we/waddr/wdata    commit from S[DEPTH]
//     retire_cnt           count of valid lanes leaving S[DEPTH]
//     ex_pc, debug_wb_*    (PIPE_DEBUG_EN only) PC pipe and commit trace
module exwb_lane_pipe #(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int RAW   = 5,
   parameter int DEPTH = 2,
   parameter int NRP   = 2*LANES,
   localparam int BW   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic [LANES-1:0]      ex_valid,
   input  logic [LANES-1:0]      ex_we,
   input  logic [LANES*RAW-1:0]  ex_waddr,
   input  logic [LANES*XLEN-1:0] ex_wdata,
   input  logic [LANES-1:0]      ex_late,
   input  logic                  ex_br_hit,
   input  logic [BW-1:0]         ex_br_lane,
   input  logic [LANES*XLEN-1:0] s1_late_data,
   input  logic [NRP*RAW-1:0]    rd_addr,
   input  logic [NRP*XLEN-1:0]   rd_data_in,
   output logic [NRP*XLEN-1:0]   rd_data_out,
   output logic [NRP-1:0]        fwd_hazard,
   output logic [LANES-1:0]      wb_we,
   output logic [LANES*RAW-1:0]  wb_waddr,
   output logic [LANES*XLEN-1:0] wb_wdata,
   output logic [31:0]           retire_cnt
`ifdef PIPE_DEBUG_EN
   ,
   input  logic [LANES*32-1:0]   ex_pc,
   output logic [LANES*32-1:0]   debug_wb_pc,
   output logic [LANES*4-1:0]    debug_wb_rf_we,
   output logic [LANES*RAW-1:0]  debug_wb_rf_wnum,
   output logic [LANES*XLEN-1:0] debug_wb_rf_wdata
`endif
);
   logic [DEPTH:1][LANES-1:0]           s_valid;
   logic [DEPTH:1][LANES-1:0]           s_we;
   logic [DEPTH:1][LANES-1:0][RAW-1:0]  s_waddr;
   logic [DEPTH:1][LANES-1:0][XLEN-1:0] s_data;
   logic [LANES-1:0]                    s1_late;
   logic [LANES-1:0][XLEN-1:0]          late_d;
   logic [LANES-1:0][XLEN-1:0]          s2_data;
   logic [LANES-1:0]                    eff;
   logic [31:0]                         pop;
   assign late_d = s1_late_data;
   // the branch lane itself survives; only strictly younger lanes are dropped
   always_comb begin
      eff = '0;
      for (int l = 0; l < LANES; l++)
         eff[l] = ex_valid[l] & ~(ex_br_hit & (l > int'(ex_br_lane)));
   end
   // late results replace the ALU value as the entry leaves S1
   always_comb begin
      s2_data = '0;
      for (int l = 0; l < LANES; l++)
         s2_data[l] = s1_late[l] ? late_d[l] : s_data[1][l];
   end
   always_comb begin
      pop = '0;
      for (int l = 0; l < LANES; l++)
         pop = pop + 32'(s_valid[DEPTH][l]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s_valid    <= '0;
         s_we       <= '0;
         s_waddr    <= '0;
         s_data     <= '0;
         s1_late    <= '0;
         retire_cnt <= '0;
      end else if (!stall) begin
         s_valid[1] <= eff;
         s_we[1]    <= ex_we;
         s_waddr[1] <= ex_waddr;
         s_data[1]  <= ex_wdata;
         s1_late    <= ex_late;
         s_valid[2] <= s_valid[1];
         s_we[2]    <= s_we[1];
         s_waddr[2] <= s_waddr[1];
         s_data[2]  <= s2_data;
         for (int k = 2; k < DEPTH; k++) begin
            s_valid[k+1] <= s_valid[k];
            s_we[k+1]    <= s_we[k];
            s_waddr[k+1] <= s_waddr[k];
            s_data[k+1]  <= s_data[k];
         end
         retire_cnt <= retire_cnt + pop;
      end
   end
   // commit only on advancing cycles so a held WB entry is written exactly once
   assign wb_we    = s_valid[DEPTH] & s_we[DEPTH] & {LANES{~stall}};
   assign wb_waddr = s_waddr[DEPTH];
   assign wb_wdata = s_data[DEPTH];
   // oldest stage first, lanes ascending: the last match seen (nearest stage, youngest lane) wins
   for (genvar p = 0; p < NRP; p++) begin : g_fwd
      logic [RAW-1:0]  a;
      logic [XLEN-1:0] d;
      logic            h;
      assign a = rd_addr[p*RAW +: RAW];
      always_comb begin
         d = rd_data_in[p*XLEN +: XLEN];
         h = 1'b0;
         for (int k = DEPTH; k >= 1; k--)
            for (int l = 0; l < LANES; l++)
               if (s_valid[k][l] && s_we[k][l] && s_waddr[k][l] == a && a != '0) begin
                  d = (k == 1 && s1_late[l]) ? late_d[l] : s_data[k][l];
                  h = (k == 1) && s1_late[l] && stall;
               end
      end
      assign rd_data_out[p*XLEN +: XLEN] = d;
      assign fwd_hazard[p] = h;
   end
`ifdef PIPE_DEBUG_EN
   logic [DEPTH:1][LANES-1:0][31:0] s_pc;
   always_ff @(posedge clk) begin
      if (rst)
         s_pc <= '0;
      else if (!stall) begin
         s_pc[1] <= ex_pc;
         for (int k = 1; k < DEPTH; k++)
            s_pc[k+1] <= s_pc[k];
      end
   end
   assign debug_wb_pc       = s_pc[DEPTH];
   assign debug_wb_rf_wnum  = wb_waddr;
   assign debug_wb_rf_wdata = wb_wdata;
   for (genvar l = 0; l < LANES; l++) begin : g_dbg
      assign debug_wb_rf_we[l*4 +: 4] = {4{wb_we[l]}};
   end
`endif
endmodule

// File: tb/tb_exwb_lane_pipe.sv
// tb_exwb_lane_pipe: directed vector table plus hand sequences for exwb_lane_pipe (LANES=2, DEPTH=2)
module tb_exwb_lane_pipe;
   localparam int L = 2, X = 32, R = 5, N = 4;
   localparam logic [31:0] RI = 32'h100;
   logic clk = 1'b0;
   logic rst, stall, ex_br_hit;
   logic [L-1:0] ex_valid, ex_we, ex_late, wb_we;
   logic [L*R-1:0] ex_waddr, wb_waddr;
   logic [L*X-1:0] ex_wdata, s1_late_data, wb_wdata;
   logic [0:0] ex_br_lane;
   logic [N*R-1:0] rd_addr;
   logic [N*X-1:0] rd_data_in, rd_data_out;
   logic [N-1:0] fwd_hazard;
   logic [31:0] retire_cnt;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   exwb_lane_pipe dut (
      .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_we(ex_we),
      .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_late(ex_late), .ex_br_hit(ex_br_hit),
      .ex_br_lane(ex_br_lane), .s1_late_data(s1_late_data), .rd_addr(rd_addr),
      .rd_data_in(rd_data_in), .rd_data_out(rd_data_out), .fwd_hazard(fwd_hazard),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .retire_cnt(retire_cnt));
   typedef struct {
      logic [31:0] stall, bh, bl, v, w, lt, wa0, wd0, wa1, wd1, ld1, ra;
      logic [31:0] ewe, ewa0, ewd0, ewa1, ewd1, erd, ehz, erc;
   } vec_t;
   vec_t vec[$];
   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
      end
   endtask
   task automatic idle();
      stall = 0; ex_valid = 0; ex_we = 0; ex_late = 0; ex_br_hit = 0; ex_br_lane = 0;
      ex_waddr = 0; ex_wdata = 0; s1_late_data = 0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      // stall,bh,bl,v,w,lt, wa0,wd0,wa1,wd1,ld1,ra, ewe,ewa0,ewd0,ewa1,ewd1,erd,ehz,erc
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,3, 0,0,0,0,0,'h100,0,0});
      vec.push_back(vec_t'{0,0,0,3,3,0, 3,'h11,4,'h22,0,3, 0,0,0,0,0,'h100,0,0});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,3, 0,0,0,0,0,'h11,0,0});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,4, 3,3,'h11,4,'h22,'h22,0,0});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,4, 0,0,0,0,0,'h100,0,2});
      vec.push_back(vec_t'{0,0,0,1,1,0, 5,'hA,0,0,0,5, 0,0,0,0,0,'h100,0,2});
      vec.push_back(vec_t'{0,0,0,2,2,0, 0,0,5,'hB,0,5, 0,0,0,0,0,'hA,0,2});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,5, 1,5,'hA,0,0,'hB,0,2});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,5, 2,0,0,5,'hB,'hB,0,3});
      vec.push_back(vec_t'{0,0,0,1,1,0, 5,'hA,0,0,0,5, 0,0,0,0,0,'h100,0,4});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,5, 0,0,0,0,0,'hA,0,4});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,5, 1,5,'hA,0,0,'hA,0,4});
      vec.push_back(vec_t'{0,0,0,1,1,0, 0,'h55,0,0,0,0, 0,0,0,0,0,'h100,0,5});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,'h100,0,5});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,0, 1,0,'h55,0,0,'h100,0,5});
      vec.push_back(vec_t'{0,1,0,3,3,0, 8,'h81,9,'h91,0,9, 0,0,0,0,0,'h100,0,6});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,9, 0,0,0,0,0,'h100,0,6});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,9, 1,8,'h81,0,0,'h100,0,6});
      vec.push_back(vec_t'{0,1,1,3,3,0, 10,'hA0,11,'hB0,0,11, 0,0,0,0,0,'h100,0,7});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,11, 0,0,0,0,0,'hB0,0,7});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,10, 3,10,'hA0,11,'hB0,'hA0,0,7});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,10, 0,0,0,0,0,'h100,0,9});
      vec.push_back(vec_t'{0,0,0,2,2,2, 0,0,7,'h1234,0,7, 0,0,0,0,0,'h100,0,9});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,'hDEAD,7, 0,0,0,0,0,'hDEAD,0,9});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,'hBAD,7, 2,0,0,7,'hDEAD,'hDEAD,0,9});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,7, 0,0,0,0,0,'h100,0,10});
      vec.push_back(vec_t'{0,0,0,1,1,0, 12,'hC0,0,0,0,12, 0,0,0,0,0,'h100,0,10});
      vec.push_back(vec_t'{0,0,0,2,2,2, 0,0,13,'h999,0,12, 0,0,0,0,0,'hC0,0,10});
      for (int i = 0; i < 3; i++)
         vec.push_back(vec_t'{1,1,0,3,3,0, 14,'hE,15,'hF,'h777,13, 0,0,0,0,0,'h777,1,10});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,'h1313,13, 1,12,'hC0,0,0,'h1313,0,10});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,13, 2,0,0,13,'h1313,'h1313,0,11});
      vec.push_back(vec_t'{0,0,0,0,0,0, 0,0,0,0,0,13, 0,0,0,0,0,'h100,0,12});
      idle();
      rst = 1; rd_addr = 0; rd_data_in = {N{RI}};
      repeat (2) @(posedge clk);
      #1 rst = 0;
      foreach (vec[i]) begin
         stall = vec[i].stall[0]; ex_br_hit = vec[i].bh[0]; ex_br_lane = vec[i].bl[0:0];
         ex_valid = vec[i].v[1:0]; ex_we = vec[i].w[1:0]; ex_late = vec[i].lt[1:0];
         ex_waddr = {vec[i].wa1[4:0], vec[i].wa0[4:0]};
         ex_wdata = {vec[i].wd1, vec[i].wd0};
         s1_late_data = {vec[i].ld1, 32'h0};
         rd_addr = {N{vec[i].ra[4:0]}};
         #1;
         chk("wb_we", i, 32'(wb_we), vec[i].ewe);
         if (vec[i].ewe[0]) begin
            chk("wb_waddr0", i, 32'(wb_waddr[4:0]), vec[i].ewa0);
            chk("wb_wdata0", i, wb_wdata[31:0], vec[i].ewd0);
         end
         if (vec[i].ewe[1]) begin
            chk("wb_waddr1", i, 32'(wb_waddr[9:5]), vec[i].ewa1);
            chk("wb_wdata1", i, wb_wdata[63:32], vec[i].ewd1);
         end
         chk("rd_data_out0", i, rd_data_out[31:0], vec[i].erd);
         chk("fwd_hazard0", i, 32'(fwd_hazard[0]), vec[i].ehz);
         chk("retire_cnt", i, retire_cnt, vec[i].erc);
         tick();
      end
      // independent read ports: lane1 writes r20, ports read r0/r20/r21/r20
      idle();
      ex_valid = 2'b10; ex_we = 2'b10; ex_waddr = {5'd20, 5'd0}; ex_wdata = {32'h2020, 32'h0};
      tick();
      idle();
      rd_addr = {5'd20, 5'd21, 5'd20, 5'd0};
      rd_data_in = {32'h330, 32'h320, 32'h310, 32'h300};
      #1;
      chk("port0_r0", 100, rd_data_out[31:0], 32'h300);
      chk("port1_r20", 100, rd_data_out[63:32], 32'h2020);
      chk("port2_r21", 100, rd_data_out[95:64], 32'h320);
      chk("port3_r20", 100, rd_data_out[127:96], 32'h2020);
      // reset while stalled with a full pipe
      ex_valid = 2'b11; ex_we = 2'b11; ex_waddr = {5'd2, 5'd1}; ex_wdata = {32'h22, 32'h11};
      tick();
      idle();
      rd_addr = {5'd2, 5'd1, 5'd2, 5'd1};
      #1;
      chk("pre_rst_fwd", 101, rd_data_out[31:0], 32'h11);
      stall = 1; rst = 1;
      tick();
      rst = 0; stall = 0;
      #1;
      chk("rst_wb_we", 102, 32'(wb_we), 32'h0);
      chk("rst_retire", 102, retire_cnt, 32'h0);
      chk("rst_rd_data", 102, rd_data_out[127:0] == rd_data_in ? 32'h1 : 32'h0, 32'h1);
      tick();
      chk("rst_retire_next", 103, retire_cnt, 32'h0);
      chk("rst_wb_we_next", 103, 32'(wb_we), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
